mem_arbiter: RTL and testbench

Two-port request arbiter in front of the single-port 64 KiB synchronous RAM (`memory`). It shares the RAM between the CPU core (port 0) and the block-transfer/DMA engine (port 1). It accepts at most one access per cycle, drives the RAM address, write-data and write-enable, and routes the one-cycle-latency read data back to the port that issued the access. A per-port lock lets a requester hold the RAM across an atomic read-modify-write sequence (TSB/TRB/TST-style).

---
 rtl/mem_arbiter.sv | 157 +++++++++++++++
 tb/tb_mem_arbiter.sv | 269 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/mem_arbiter.sv
// mem_arbiter: shares one single-port synchronous RAM between the CPU core
// (port 0) and the DMA engine (port 1). It accepts at most one access per cycle
// and routes the one-cycle-latency read data back to the port that issued it.
// A per-port lock holds the RAM across an atomic read-modify-write sequence.
// Build option: define MEM_ARB_RR_EN for round-robin arbitration in IDLE.
// When it is undefined, port 0 has fixed priority.
module mem_arbiter #(
    parameter int ADDR_W = 16,
    parameter int DATA_W = 8
) (
    input  logic              clk,
    input  logic              rst_n,
    // port 0 (CPU)
    input  logic              req0_valid,
    output logic              req0_ready,
    input  logic [ADDR_W-1:0] req0_addr,
    input  logic              req0_we,
    input  logic [DATA_W-1:0] req0_wdata,
    input  logic              req0_lock,
    output logic              rsp0_valid,
    output logic [DATA_W-1:0] rsp0_rdata,
    // port 1 (DMA)
    input  logic              req1_valid,
    output logic              req1_ready,
    input  logic [ADDR_W-1:0] req1_addr,
    input  logic              req1_we,
    input  logic [DATA_W-1:0] req1_wdata,
    input  logic              req1_lock,
    output logic              rsp1_valid,
    output logic [DATA_W-1:0] rsp1_rdata,
    // RAM side
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_din,
    output logic              mem_we,
    input  logic [DATA_W-1:0] mem_dout
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        LOCK0 = 2'd1,
        LOCK1 = 2'd2
    } state_t;

    state_t            state_q;
    logic              rsp_vld_q;   // an access was accepted last cycle
    logic              rsp_port_q;  // which port owns that response
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [DATA_W-1:0] din_q, din_d;
    logic              gnt0, gnt1;

`ifdef MEM_ARB_RR_EN
    logic              ptr_q;       // preferred port when both request in IDLE
`endif

    // Grant selection: the lock restricts eligibility, and arbitration applies only in IDLE.
    always_comb begin
        // NOTE: every signal written here gets a default first, so no latch is inferred.
        gnt0 = 1'b0;
        gnt1 = 1'b0;
        if (rst_n) begin
            unique case (state_q)
                IDLE: begin
`ifdef MEM_ARB_RR_EN
                    if (req0_valid && req1_valid) begin
                        gnt0 = ~ptr_q;
                        gnt1 = ptr_q;
                    end else begin
                        gnt0 = req0_valid;
                        gnt1 = req1_valid;
                    end
`else
                    gnt0 = req0_valid;
                    gnt1 = req1_valid & ~req0_valid;
`endif
                end
                LOCK0:   gnt0 = req0_valid;
                LOCK1:   gnt1 = req1_valid;
                default: ;
            endcase
        end
    end

    assign req0_ready = gnt0;
    assign req1_ready = gnt1;

    // RAM drive: the winning port passes straight through; otherwise the last grant is held and no write occurs.
    always_comb begin
        addr_d = addr_q;
        din_d  = din_q;
        mem_we = 1'b0;
        if (gnt0) begin
            addr_d = req0_addr;
            din_d  = req0_wdata;
            mem_we = req0_we;
        end else if (gnt1) begin
            addr_d = req1_addr;
            din_d  = req1_wdata;
            mem_we = req1_we;
        end
    end

    assign mem_addr = addr_d;
    assign mem_din  = din_d;

    // Lock FSM and response-owner pipeline; a reset discards any lock and any response in flight.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= IDLE;
            rsp_vld_q  <= 1'b0;
            rsp_port_q <= 1'b0;
        end else begin
            // NOTE: non-blocking assignments, so every register samples pre-edge values.
            rsp_vld_q  <= gnt0 | gnt1;
            rsp_port_q <= gnt1;
            unique case (state_q)
                IDLE: begin
                    if (gnt0 && req0_lock)      state_q <= LOCK0;
                    else if (gnt1 && req1_lock) state_q <= LOCK1;
                end
                LOCK0:   if (gnt0 && !req0_lock) state_q <= IDLE;
                LOCK1:   if (gnt1 && !req1_lock) state_q <= IDLE;
                default: state_q <= IDLE;
            endcase
        end
    end

    // Hold the last granted address and write data for the cycles with no grant.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            addr_q <= '0;
            din_q  <= '0;
        end else begin
            addr_q <= addr_d;
            din_q  <= din_d;
        end
    end

`ifdef MEM_ARB_RR_EN
    // Round-robin pointer: after a grant, prefer the other port next time.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ptr_q <= 1'b0;
        end else if (gnt0) begin
            ptr_q <= 1'b1;
        end else if (gnt1) begin
            ptr_q <= 1'b0;
        end
    end
`endif

    // The response goes to the owner only; the other port sees zero data.
    assign rsp0_valid = rsp_vld_q & ~rsp_port_q;
    assign rsp1_valid = rsp_vld_q &  rsp_port_q;
    assign rsp0_rdata = rsp0_valid ? mem_dout : '0;
    assign rsp1_rdata = rsp1_valid ? mem_dout : '0;

endmodule

// File: tb/tb_mem_arbiter.sv
// Testbench for mem_arbiter. It contains a read-first synchronous RAM, a
// transaction-level reference model checked on every negative clock edge, and
// directed scenarios that have literal expected values.
module tb_mem_arbiter;

    logic        clk;
    logic        rst_n;
    logic        req0_valid, req0_ready, req0_we, req0_lock, rsp0_valid;
    logic [15:0] req0_addr;
    logic [7:0]  req0_wdata, rsp0_rdata;
    logic        req1_valid, req1_ready, req1_we, req1_lock, rsp1_valid;
    logic [15:0] req1_addr;
    logic [7:0]  req1_wdata, rsp1_rdata;
    logic [15:0] mem_addr;
    logic [7:0]  mem_din, mem_dout;
    logic        mem_we;

    int n_checks = 0;
    int n_fail   = 0;

    mem_arbiter #(.ADDR_W(16), .DATA_W(8)) dut (
        .clk(clk), .rst_n(rst_n),
        .req0_valid(req0_valid), .req0_ready(req0_ready), .req0_addr(req0_addr),
        .req0_we(req0_we), .req0_wdata(req0_wdata), .req0_lock(req0_lock),
        .rsp0_valid(rsp0_valid), .rsp0_rdata(rsp0_rdata),
        .req1_valid(req1_valid), .req1_ready(req1_ready), .req1_addr(req1_addr),
        .req1_we(req1_we), .req1_wdata(req1_wdata), .req1_lock(req1_lock),
        .rsp1_valid(rsp1_valid), .rsp1_rdata(rsp1_rdata),
        .mem_addr(mem_addr), .mem_din(mem_din), .mem_we(mem_we), .mem_dout(mem_dout)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Read-first RAM: a write returns the old contents.
    logic [7:0] ram [0:65535];
    always @(posedge clk) begin
        mem_dout <= ram[mem_addr];
        if (mem_we) ram[mem_addr] <= mem_din;
    end

    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
        end
    endtask

    // ---------------- reference model ----------------
    logic [7:0]  mm [0:65535];  // shadow of RAM contents
    int          lk;            // lock owner port, -1 when none
    logic [15:0] h_addr;
    logic [7:0]  h_din;
    bit          p_vld, p_port;
    logic [7:0]  p_data;
`ifdef MEM_ARB_RR_EN
    bit          ptr_m;
`endif

    always @(negedge clk) begin
        bit el0, el1, ew, wl;
        int win;
        logic [15:0] ea;
        logic [7:0]  ed;
        if (!rst_n) begin
            check("rst_ready0", req0_ready, 0);
            check("rst_ready1", req1_ready, 0);
            check("rst_rsp0_valid", rsp0_valid, 0);
            check("rst_rsp1_valid", rsp1_valid, 0);
            check("rst_rsp0_rdata", rsp0_rdata, 0);
            check("rst_rsp1_rdata", rsp1_rdata, 0);
            check("rst_mem_we", mem_we, 0);
            check("rst_mem_addr", mem_addr, 0);
            check("rst_mem_din", mem_din, 0);
            lk = -1; h_addr = 0; h_din = 0; p_vld = 0; p_port = 0; p_data = 0;
`ifdef MEM_ARB_RR_EN
            ptr_m = 0;
`endif
        end else begin
            el0 = req0_valid && (lk != 1);
            el1 = req1_valid && (lk != 0);
            win = -1;
            if (el0 && el1) begin
`ifdef MEM_ARB_RR_EN
                win = ptr_m ? 1 : 0;
`else
                win = 0;
`endif
            end else if (el0) win = 0;
            else if (el1) win = 1;
            check("m_ready0", req0_ready, win == 0);
            check("m_ready1", req1_ready, win == 1);
            if (win == 0) begin ea = req0_addr; ed = req0_wdata; ew = req0_we; wl = req0_lock; end
            else if (win == 1) begin ea = req1_addr; ed = req1_wdata; ew = req1_we; wl = req1_lock; end
            else begin ea = h_addr; ed = h_din; ew = 0; wl = 0; end
            check("m_mem_addr", mem_addr, ea);
            check("m_mem_din", mem_din, ed);
            check("m_mem_we", mem_we, ew);
            check("m_rsp0_valid", rsp0_valid, p_vld && !p_port);
            check("m_rsp1_valid", rsp1_valid, p_vld && p_port);
            check("m_rsp0_rdata", rsp0_rdata, (p_vld && !p_port) ? p_data : 8'h00);
            check("m_rsp1_rdata", rsp1_rdata, (p_vld && p_port) ? p_data : 8'h00);
            p_vld = (win >= 0);
            if (win >= 0) begin
                p_port = (win == 1);
                p_data = mm[ea];
                if (ew) mm[ea] = ed;
                h_addr = ea;
                h_din  = ed;
`ifdef MEM_ARB_RR_EN
                ptr_m = (win == 0);
`endif
                if (lk < 0 && wl) lk = win;
                else if (lk == win && !wl) lk = -1;
            end
        end
    end

    // ---------------- stimulus helpers ----------------
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic obs();
        @(negedge clk);
    endtask

    task automatic set0(input bit v, input logic [15:0] a, input bit w, input logic [7:0] d, input bit l);
        req0_valid = v; req0_addr = a; req0_we = w; req0_wdata = d; req0_lock = l;
    endtask

    task automatic set1(input bit v, input logic [15:0] a, input bit w, input logic [7:0] d, input bit l);
        req1_valid = v; req1_addr = a; req1_we = w; req1_wdata = d; req1_lock = l;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int g0, g1;
        for (int i = 0; i < 65536; i++) begin
            ram[i] = 8'h00;
            mm[i]  = 8'h00;
        end
        ram[16'h1234] = 8'h5A;
        mm[16'h1234]  = 8'h5A;

        // Reset with both ports requesting
        rst_n = 1'b0;
        set0(1, 16'h0000, 0, 8'h00, 0);
        set1(1, 16'h0000, 0, 8'h00, 0);
        repeat (3) begin
            obs();
            check("reset_ready0", req0_ready, 0);
            check("reset_ready1", req1_ready, 0);
        end
        step(); rst_n = 1'b1;
        obs();
        check("post_reset_grant0", req0_ready, 1);
        check("post_reset_grant1", req1_ready, 0);
        step(); set0(0, 0, 0, 0, 0); set1(0, 0, 0, 0, 0);
        obs();

        // Single read from the preloaded location
        step(); set0(1, 16'h1234, 0, 8'h00, 0);
        obs(); check("read_ready0", req0_ready, 1);
        step(); set0(0, 16'h1234, 0, 8'h00, 0);
        obs();
        check("read_rsp0_valid", rsp0_valid, 1);
        check("read_rsp0_rdata", rsp0_rdata, 8'h5A);
        check("read_rsp1_valid", rsp1_valid, 0);

        // Top address: write, read back, then check the held address
        step(); set0(1, 16'hFFFF, 1, 8'hA5, 0);
        obs();
        step(); set0(1, 16'hFFFF, 0, 8'h00, 0);
        obs(); check("top_wr_old", rsp0_rdata, 8'h00);
        step(); set0(0, 16'h0000, 0, 8'h00, 0);
        obs();
        check("top_rd_data", rsp0_rdata, 8'hA5);
        check("held_addr", mem_addr, 16'hFFFF);
        check("held_we", mem_we, 0);

        // Port 1 writes, then reads the same location back to back
        step(); set1(1, 16'h0010, 1, 8'hC3, 0);
        obs(); check("wr_ready1", req1_ready, 1);
        step(); set1(1, 16'h0010, 0, 8'h00, 0);
        obs();
        check("rd_ready1", req1_ready, 1);
        check("wr_rsp1_valid", rsp1_valid, 1);
        check("wr_rsp1_old", rsp1_rdata, 8'h00);
        step(); set1(0, 16'h0010, 0, 8'h00, 0);
        obs();
        check("rd_rsp1_valid", rsp1_valid, 1);
        check("rd_rsp1_new", rsp1_rdata, 8'hC3);

        // Contention: both ports valid for four cycles
        g0 = 0; g1 = 0;
        step(); set0(1, 16'h0100, 0, 8'h00, 0); set1(1, 16'h0200, 0, 8'h00, 0);
        for (int i = 0; i < 4; i++) begin
            obs();
            if (req0_ready) g0++;
            if (req1_ready) g1++;
`ifdef MEM_ARB_RR_EN
            check("cont_ready0", req0_ready, (i % 2) == 0);
`else
            check("cont_ready0", req0_ready, 1);
`endif
            if (i < 3) step();
        end
`ifdef MEM_ARB_RR_EN
        check("cont_g0", g0, 2);
        check("cont_g1", g1, 2);
`else
        check("cont_g0", g0, 4);
        check("cont_g1", g1, 0);
`endif
        step(); set0(0, 0, 0, 0, 0); set1(0, 0, 0, 0, 0);
        obs();

        // Lock: port 1 read-modify-write at 0x2000 while port 0 waits
        step(); set1(1, 16'h2000, 0, 8'h00, 1);
        obs();
        check("lock_ready1", req1_ready, 1);
        check("lock_c1_ready0", req0_ready, 0);
        step(); set1(0, 16'h2000, 0, 8'h00, 1); set0(1, 16'h3000, 0, 8'h00, 0);
        obs();
        check("lock_c2_ready0", req0_ready, 0);
        check("lock_rd_rsp1", rsp1_valid, 1);
        step(); set1(1, 16'h2000, 1, 8'h77, 0);
        obs();
        check("lock_c3_ready0", req0_ready, 0);
        check("lock_c3_ready1", req1_ready, 1);
        step(); set1(0, 16'h2000, 0, 8'h00, 0);
        obs();
        check("unlock_ready0", req0_ready, 1);
        check("unlock_wr_old", rsp1_rdata, 8'h00);
        step(); set0(0, 16'h3000, 0, 8'h00, 0);
        obs(); check("unlock_rsp0", rsp0_valid, 1);

        // Reset mid-lock with a response in flight
        step(); set0(1, 16'h1234, 0, 8'h00, 1);
        obs(); check("ml_ready0", req0_ready, 1);
        step(); set0(0, 16'h1234, 0, 8'h00, 1); set1(1, 16'h0010, 0, 8'h00, 0); rst_n = 1'b0;
        obs();
        check("ml_rst_rsp0", rsp0_valid, 0);
        check("ml_rst_ready1", req1_ready, 0);
        step(); rst_n = 1'b1;
        obs();
        check("ml_rel_ready1", req1_ready, 1);
        check("ml_rel_rsp0", rsp0_valid, 0);
        step(); set1(0, 16'h0010, 0, 8'h00, 0);
        obs();
        check("ml_rsp1_valid", rsp1_valid, 1);
        check("ml_rsp1_rdata", rsp1_rdata, 8'hC3);
        check("ml_no_rsp0", rsp0_valid, 0);
        step();
        obs();

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
